multicycle_cu: RTL and testbench
================================

Name: multicycle_cu

Overview:
- Parametrised multi-cycle control unit. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states instead of decoding the opcode in a single clocked step.
- Adds a fetch handshake, a memory-ready handshake with a timeout, illegal-opcode trapping, a halt state, and a retired-instruction counter.
- Sits between the instruction source, the register file/ALU datapath and the data memory.

Parameters:
- OPCODE_W, 4, opcode width. Must be >= 4. Encodings: LOAD=0, STORE=1, ADD=2, SUB=3, LS=4, CMP=5, HALT=all ones; every other value is illegal.
- MEM_TIMEOUT, 16, maximum cycles spent in MEM waiting for mem_ready. 0 disables the timeout.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  allows the unit to leave IDLE and to fetch
- opcode  in  OPCODE_W  instruction opcode, sampled only in FETCH when instr_valid=1
- instr_valid  in  1  opcode is valid this cycle
- mem_ready  in  1  data memory has completed the access this cycle
- err_clr  in  1  leaves ERR for IDLE
- fetch_req  out  1  request the next instruction
- pc_en  out  1  advance the PC, single-cycle pulse
- reg_write_en  out  1  register file write enable
- mem_write_en  out  1  data memory write
- mem_read_en  out  1  data memory read
- mem_to_reg  out  1  writeback mux selects memory data
- mem_op  out  1  memory instruction in progress
- ALU_select  out  2  ALU function: 00 add, 01 sub, 10 LS, 11 cmp
- busy  out  1  instruction in flight (DECODE, EXEC, MEM or WB)
- halted  out  1  HALT state
- err  out  1  ERR state (illegal opcode or memory timeout)
- retired  out  CNT_W  count of completed instructions; wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=1 at an edge, including mid-instruction):
  - state=IDLE; op_q=0; wait counter=0; retired=0.
  - All outputs 0 in the following cycle.
  - rst has priority over every other input.
- Output timing:
  - Outputs are decoded from the current state and the latched op_q only.
  - No output depends combinationally on opcode, instr_valid or mem_ready.
- IDLE: all outputs 0. Go to FETCH when run=1.
- FETCH: fetch_req=1.
  - instr_valid=1: capture op_q<=opcode, go to DECODE.
  - Else if run=0: go to IDLE.
  - Else: stay.
  - instr_valid has priority over run=0.
- DECODE: one cycle, busy=1. Next state by op_q:
  - illegal -> ERR
  - HALT -> HALT
  - LOAD or STORE -> MEM (wait counter cleared)
  - ADD, SUB, LS, CMP -> EXEC
- EXEC: one cycle. ALU_select from op_q (ADD 00, SUB 01, LS 10, CMP 11). Next state WB.
- MEM: mem_op=1. mem_read_en=1 for LOAD; mem_write_en=1 for STORE.
  - mem_ready=1: go to WB.
  - Else the wait counter increments.
  - With MEM_TIMEOUT>0 and the counter at MEM_TIMEOUT-1 with mem_ready=0: go to ERR.
  - mem_ready=1 on that same cycle wins; the access completes normally.
- WB: one cycle, pc_en=1. Increment retired. Next state FETCH.
  - ALU ops: reg_write_en=1, ALU_select held at its EXEC value.
  - LOAD: reg_write_en=1, mem_to_reg=1, mem_op=1.
  - STORE: reg_write_en=0, mem_op=1, mem_write_en=0.
- Outside EXEC and WB, ALU_select=00.
- run=0 during DECODE, EXEC, MEM or WB is ignored: the instruction always completes.
- HALT: halted=1, fetch_req=0. Exit only via rst. HALT does not increment retired.
- ERR: err=1, all enables 0. err_clr=1 -> IDLE; otherwise stay. err_clr outside ERR has no effect.
- Instruction latency with instr_valid already high in FETCH:
  - ALU ops: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Memory ops: 4 cycles plus the number of mem_ready wait cycles.

Test Plan:
- rst=1 mid-MEM of a LOAD with mem_read_en=1 -> next cycle all outputs 0, retired=0, state IDLE, stays IDLE while run=0.
- run=1, instr_valid=1, opcode=3 -> fetch_req, DECODE, then EXEC with ALU_select=01, then WB with reg_write_en=1 and pc_en=1; retired 0->1; 4 cycles total.
- LOAD with mem_ready delayed 3 cycles -> mem_read_en held for 4 MEM cycles; WB has mem_to_reg=1 and reg_write_en=1. STORE with immediate ready -> mem_write_en for 1 cycle; WB has reg_write_en=0 and pc_en=1.
- MEM_TIMEOUT=4, STORE, mem_ready never asserted -> ERR after exactly 4 MEM cycles with err=1. Repeat with mem_ready rising on the 4th cycle -> WB, no ERR. Then err_clr=1 in ERR -> IDLE.
- opcode=7 -> ERR after DECODE, retired unchanged. opcode=4'hF -> halted=1; held for 10 cycles with run=1 and instr_valid=1, no fetch_req; rst required to exit.
- CNT_W=2, five ADDs back-to-back -> retired sequence 1,2,3,0,1. run dropped during EXEC -> instruction completes, then FETCH->IDLE when instr_valid=0.

Source files
------------

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing
// with memory timeout, illegal-opcode trap, halt and retire counter.
module multicycle_cu #(
  parameter int OPCODE_W    = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                instr_valid,
  input  logic                mem_ready,
  input  logic                err_clr,
  output logic                fetch_req,
  output logic                pc_en,
  output logic                reg_write_en,
  output logic                mem_write_en,
  output logic                mem_read_en,
  output logic                mem_to_reg,
  output logic                mem_op,
  output logic [1:0]          ALU_select,
  output logic                busy,
  output logic                halted,
  output logic                err,
  output logic [CNT_W-1:0]    retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_LS    = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_CMP   = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_HALT  = '1;

  localparam int WAIT_W =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int LIM_I =
    (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(LIM_I);

  logic [2:0]          state;
  logic [2:0]          next;
  logic [OPCODE_W-1:0] op_q;
  logic [WAIT_W-1:0]   wcnt;
  logic                is_load;
  logic                is_store;
  logic                is_alu;
  logic                is_halt;
  logic [1:0]          alu_fn;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_alu   = 1'b0;
    is_halt  = 1'b0;
    alu_fn   = 2'b00;
    unique case (1'b1)
      (op_q == OP_LOAD):  is_load  = 1'b1;
      (op_q == OP_STORE): is_store = 1'b1;
      (op_q == OP_ADD):   is_alu   = 1'b1;
      (op_q == OP_SUB): begin
        is_alu = 1'b1;
        alu_fn = 2'b01;
      end
      (op_q == OP_LS): begin
        is_alu = 1'b1;
        alu_fn = 2'b10;
      end
      (op_q == OP_CMP): begin
        is_alu = 1'b1;
        alu_fn = 2'b11;
      end
      (op_q == OP_HALT):  is_halt  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:   if (run) next = S_FETCH;
      S_FETCH: begin
        if (instr_valid) next = S_DECODE;
        else if (!run)   next = S_IDLE;
      end
      S_DECODE: begin
        if (is_halt)                  next = S_HALT;
        else if (is_load || is_store) next = S_MEM;
        else if (is_alu)              next = S_EXEC;
        else                          next = S_ERR;
      end
      S_EXEC:   next = S_WB;
      S_MEM: begin
        // a late mem_ready on the final allowed cycle still completes
        if (mem_ready)
          next = S_WB;
        else if (MEM_TIMEOUT > 0 && wcnt == LIMIT)
          next = S_ERR;
      end
      S_WB:     next = S_FETCH;
      S_HALT:   next = S_HALT;
      S_ERR:    if (err_clr) next = S_IDLE;
      default:  next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= '0;
      wcnt    <= '0;
      retired <= '0;
    end else begin
      state <= next;
      if (state == S_FETCH && instr_valid)
        op_q <= opcode;
      if (state == S_DECODE)
        wcnt <= '0;
      else if (state == S_MEM && !mem_ready)
        wcnt <= wcnt + 1'b1;
      if (state == S_WB)
        retired <= retired + 1'b1;
    end
  end

  always_comb begin
    fetch_req    = (state == S_FETCH);
    halted       = (state == S_HALT);
    err          = (state == S_ERR);
    busy         = (state == S_DECODE) || (state == S_EXEC) ||
                   (state == S_MEM)    || (state == S_WB);
    pc_en        = 1'b0;
    reg_write_en = 1'b0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    mem_to_reg   = 1'b0;
    mem_op       = 1'b0;
    ALU_select   = 2'b00;
    unique case (state)
      S_EXEC: if (is_alu) ALU_select = alu_fn;
      S_MEM: begin
        mem_op       = 1'b1;
        mem_read_en  = is_load;
        mem_write_en = is_store;
      end
      S_WB: begin
        pc_en = 1'b1;
        if (is_alu) begin
          reg_write_en = 1'b1;
          ALU_select   = alu_fn;
        end
        if (is_load) begin
          reg_write_en = 1'b1;
          mem_to_reg   = 1'b1;
          mem_op       = 1'b1;
        end
        if (is_store) mem_op = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_cu.sv
// Bench for multicycle_cu: directed steps then random instruction
// stream, checked against per-instruction expected output traces.
module tb_multicycle_cu;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [3:0] opcode;
  logic       instr_valid;
  logic       mem_ready;
  logic       err_clr;
  logic       fetch_req;
  logic       pc_en;
  logic       reg_write_en;
  logic       mem_write_en;
  logic       mem_read_en;
  logic       mem_to_reg;
  logic       mem_op;
  logic [1:0] ALU_select;
  logic       busy;
  logic       halted;
  logic       err;
  logic [1:0] retired;

  int compared = 0;
  int mismatched = 0;
  int retired_exp = 0;

  localparam int FR = 11, PC = 10, RW = 9, MW = 8;
  localparam int MR = 7, MTR = 6, MOP = 5, A1 = 4;
  localparam int A0 = 3, BSY = 2, HLT = 1, ERB = 0;

  localparam int R_FETCH = 0, R_ERR = 1, R_HALT = 2;

  multicycle_cu #(
    .OPCODE_W(4),
    .MEM_TIMEOUT(4),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .opcode(opcode),
    .instr_valid(instr_valid),
    .mem_ready(mem_ready),
    .err_clr(err_clr),
    .fetch_req(fetch_req),
    .pc_en(pc_en),
    .reg_write_en(reg_write_en),
    .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en),
    .mem_to_reg(mem_to_reg),
    .mem_op(mem_op),
    .ALU_select(ALU_select),
    .busy(busy),
    .halted(halted),
    .err(err),
    .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] got();
    return {fetch_req, pc_en, reg_write_en, mem_write_en,
            mem_read_en, mem_to_reg, mem_op, ALU_select,
            busy, halted, err};
  endfunction

  // Expected outputs for a phase of an instruction with opcode op
  function automatic logic [11:0] ev(input string ph, input int op);
    logic [11:0] v;
    logic [1:0]  fn;
    v  = '0;
    fn = 2'(op - 2);
    case (ph)
      "FETCH":  v[FR] = 1'b1;
      "DECODE": v[BSY] = 1'b1;
      "EXEC": begin
        v[BSY] = 1'b1;
        {v[A1], v[A0]} = fn;
      end
      "MEM": begin
        v[BSY] = 1'b1;
        v[MOP] = 1'b1;
        v[MR]  = (op == 0);
        v[MW]  = (op == 1);
      end
      "WB": begin
        v[BSY] = 1'b1;
        v[PC]  = 1'b1;
        if (op >= 2) begin
          v[RW] = 1'b1;
          {v[A1], v[A0]} = fn;
        end
        if (op == 0) begin
          v[RW]  = 1'b1;
          v[MTR] = 1'b1;
          v[MOP] = 1'b1;
        end
        if (op == 1) v[MOP] = 1'b1;
      end
      "HALT": v[HLT] = 1'b1;
      "ERR":  v[ERB] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] e);
    compared++;
    assert (got() === e) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, got(), e);
    end
  endtask

  task automatic chk_ret(input string tag);
    logic [1:0] e;
    e = 2'(retired_exp);
    compared++;
    assert (retired === e) else begin
      mismatched++;
      $error("FAIL %s retired observed=%0d expected=%0d",
             tag, retired, e);
    end
  endtask

  // Runs one instruction starting in FETCH; waits = mem_ready delay
  task automatic do_instr(input int op, input int waits,
                          input bit drop_run, output int res);
    res = R_FETCH;
    chk("fetch", ev("FETCH", op));
    opcode = 4'(op);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    opcode = 4'($urandom);
    if (drop_run) run = 1'b0;
    chk("decode", ev("DECODE", op));
    if (op == 15) begin
      step();
      chk("halt", ev("HALT", op));
      chk_ret("halt_ret");
      res = R_HALT;
      return;
    end
    if (op > 5) begin
      step();
      chk("illegal", ev("ERR", op));
      chk_ret("illegal_ret");
      res = R_ERR;
      return;
    end
    step();
    if (op >= 2) begin
      chk("exec", ev("EXEC", op));
      step();
    end else begin
      for (int i = 0; ; i++) begin
        chk("mem", ev("MEM", op));
        if (i == waits) begin
          mem_ready = 1'b1;
          step();
          mem_ready = 1'b0;
          break;
        end
        step();
        if (i == 3) begin
          chk("timeout", ev("ERR", op));
          chk_ret("timeout_ret");
          res = R_ERR;
          return;
        end
      end
    end
    chk("wb", ev("WB", op));
    step();
    retired_exp = (retired_exp + 1) % 4;
    chk_ret("retire");
    chk("next_fetch", ev("FETCH", op));
    if (!run) begin
      step();
      chk("drop_idle", ev("IDLE", op));
      run = 1'b1;
      step();
    end
  endtask

  task automatic recover(input int res);
    if (res == R_ERR) begin
      int k;
      k = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) begin
        run = 1'($urandom);
        instr_valid = 1'($urandom);
        step();
        chk("err_hold", ev("ERR", 0));
      end
      instr_valid = 1'b0;
      run = 1'b0;
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("err_clr", ev("IDLE", 0));
      chk_ret("err_clr_ret");
      run = 1'b1;
      step();
    end else if (res == R_HALT) begin
      run = 1'b1;
      instr_valid = 1'b1;
      err_clr = 1'b1;
      for (int i = 0; i < 10; i++) begin
        step();
        chk("halt_hold", ev("HALT", 0));
      end
      err_clr = 1'b0;
      instr_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      retired_exp = 0;
      chk("halt_rst", ev("IDLE", 0));
      chk_ret("halt_rst_ret");
      step();
    end
  endtask

  initial begin
    int res;
    int op;
    int r;
    rst = 1'b1;
    run = 1'b0;
    opcode = '0;
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    err_clr = 1'b0;
    step();
    step();
    chk("reset", ev("IDLE", 0));
    chk_ret("reset_ret");
    rst = 1'b0;
    step();
    chk("idle_hold", ev("IDLE", 0));
    run = 1'b1;
    step();

    do_instr(3, 0, 1'b0, res);
    do_instr(0, 3, 1'b0, res);
    do_instr(1, 0, 1'b0, res);
    do_instr(1, 9, 1'b0, res);
    recover(res);
    do_instr(1, 3, 1'b0, res);
    do_instr(7, 0, 1'b0, res);
    recover(res);
    for (int i = 0; i < 5; i++) do_instr(2, 0, 1'b0, res);
    do_instr(4, 0, 1'b1, res);
    do_instr(5, 0, 1'b0, res);
    do_instr(15, 0, 1'b0, res);
    recover(res);

    // reset in the middle of a LOAD's memory phase
    chk("pre_load", ev("FETCH", 0));
    opcode = 4'd0;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    chk("rstmem0", ev("MEM", 0));
    step();
    chk("rstmem1", ev("MEM", 0));
    rst = 1'b1;
    run = 1'b0;
    step();
    rst = 1'b0;
    retired_exp = 0;
    chk("rst_mid", ev("IDLE", 0));
    chk_ret("rst_mid_ret");
    step();
    chk("rst_idle", ev("IDLE", 0));
    run = 1'b1;
    step();

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 19);
      if (r < 15)      op = r % 6;
      else if (r < 18) op = $urandom_range(6, 14);
      else             op = 15;
      do_instr(op, $urandom_range(0, 5),
               ($urandom_range(0, 7) == 0), res);
      recover(res);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
